apple_placer: RTL

Consumer of the snake segment stream, i.e. the pos_x/pos_y/first/last/valid sequence that the snake core emits once per scan frame. It places the apple on a free playfield cell by drawing an LFSR candidate and rejecting any candidate that hits a segment during a full scan. It detects the head reaching the apple and issues the single-cycle eat pulse that the snake core uses to grow. It sits between the snake core and the renderer and game controller.

---
 rtl/apple_placer_pkg.sv | 16 +
 rtl/apple_placer_lfsr16.sv | 25 ++
 rtl/apple_placer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/apple_placer_pkg.sv
// Shared playfield geometry and placer state encoding for the snake game blocks.
package apple_placer_pkg;

   localparam int GAME_WIDTH  = 30;
   localparam int GAME_HEIGHT = 14;
   localparam int MAX_LENGTH  = 64;

   typedef enum logic [2:0] {
      IDLE,
      PICK,
      WAIT_FIRST,
      SCAN,
      FULL
   } state_t;

endpackage

// File: rtl/apple_placer_lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11) with an entropy bit folded into bit 0.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stir,
   output logic [15:0] lfsr
);

   localparam logic [15:0] TAPS = 16'hB400;

   logic [15:0] lfsr_nxt;

   always_comb begin
      lfsr_nxt    = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
      lfsr_nxt[0] = lfsr_nxt[0] ^ stir;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) lfsr <= SEED;
      else        lfsr <= lfsr_nxt;
   end

endmodule

// File: rtl/apple_placer.sv
// Places the apple on a free cell by scanning the snake stream, and issues the eat pulse.
module apple_placer #(
   parameter int          GAME_WIDTH  = apple_placer_pkg::GAME_WIDTH,
   parameter int          GAME_HEIGHT = apple_placer_pkg::GAME_HEIGHT,
   parameter int          MAX_TRIES   = 255,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] i_pos_x,
   input  logic [3:0] i_pos_y,
   input  logic       i_pos_first,
   input  logic       i_pos_last,
   input  logic       i_pos_valid,
   input  logic       i_stir,
   output logic [4:0] o_apple_x,
   output logic [3:0] o_apple_y,
   output logic       o_apple_valid,
   output logic       o_eat,
   output logic       o_busy,
   output logic       o_full
);

   import apple_placer_pkg::*;

   localparam logic [4:0] GW        = 5'(GAME_WIDTH);
   localparam logic [3:0] GH        = 4'(GAME_HEIGHT);
   localparam logic [7:0] TRIES_MAX = 8'(MAX_TRIES);

   state_t      state, state_nxt;
   logic [15:0] lfsr;
   logic        lfsr_unused;
   logic [4:0]  xr, cx, cand_x;
   logic [3:0]  yr, cy, cand_y;
   logic [7:0]  tries;
   logic        hit, hit_nxt, seg_hit, resolve, place, eat_nxt;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk  (clk),
      .rst_n(rst_n),
      .stir (i_stir),
      .lfsr (lfsr)
   );

   assign lfsr_unused = ^{lfsr[15:12], lfsr[7:5]};

   // Limits on the playfield size keep one conditional subtract sufficient as a modulo.
   always_comb begin
      xr = lfsr[4:0];
      if (xr >= GW) xr = xr - GW;
      cx = xr + 5'd1;
      yr = lfsr[11:8];
      if (yr >= GH) yr = yr - GH;
      cy = yr + 4'd1;
   end

   assign seg_hit = (i_pos_x == cand_x) && (i_pos_y == cand_y);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= PICK;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      hit_nxt   = hit;
      resolve   = 1'b0;
      place     = 1'b0;
      eat_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (i_pos_valid && i_pos_first && i_pos_x == o_apple_x && i_pos_y == o_apple_y) begin
               eat_nxt   = 1'b1;
               state_nxt = PICK;
            end
         end
         PICK: begin
            hit_nxt   = 1'b0;
            state_nxt = WAIT_FIRST;
         end
         WAIT_FIRST: begin
            if (i_pos_valid && i_pos_first) begin
               hit_nxt   = seg_hit;
               resolve   = i_pos_last;
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            // A head sample mid-scan means the frame restarted; earlier hits are stale.
            if (i_pos_valid) begin
               hit_nxt = seg_hit | (hit & ~i_pos_first);
               resolve = i_pos_last;
            end
         end
         FULL: ;
         default: state_nxt = PICK;
      endcase
      if (resolve) begin
         if (!hit_nxt) begin
            place     = 1'b1;
            state_nxt = IDLE;
         end else if (tries < TRIES_MAX) begin
            state_nxt = PICK;
         end else begin
            state_nxt = FULL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tries         <= 8'd0;
         hit           <= 1'b0;
         o_apple_x     <= 5'd0;
         o_apple_y     <= 4'd0;
         o_apple_valid <= 1'b0;
         o_eat         <= 1'b0;
         o_busy        <= 1'b0;
         o_full        <= 1'b0;
      end else begin
         hit    <= hit_nxt;
         o_eat  <= eat_nxt;
         o_busy <= (state_nxt == PICK) || (state_nxt == WAIT_FIRST) || (state_nxt == SCAN);
         if (state_nxt == FULL) o_full <= 1'b1;
         if (eat_nxt) o_apple_valid <= 1'b0;
         if (state == PICK) tries <= tries + 8'd1;
         if (place) begin
            o_apple_x     <= cand_x;
            o_apple_y     <= cand_y;
            o_apple_valid <= 1'b1;
            tries         <= 8'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == PICK) begin
         cand_x <= cx;
         cand_y <= cy;
      end
   end

endmodule
